sum_reader: RTL

- Read-side client of the pi engine's result RAM (sum RAM, base-1024 limbs, N=10 bits each).
- After the engine reaches END, it walks addresses L-1 down to 0 through the engine's external read-address port and absorbs the RAM read latency.
- Delivers limbs MSB-first as a valid/ready stream to the display/VGA text path.
- Credit-based issue plus a small FIFO, so downstream back-pressure never drops a limb.

---
 rtl/sum_reader_pkg.sv | 31 +++
 rtl/sum_reader_if.sv | 27 ++
 rtl/sum_reader_fifo.sv | 58 +++++
 rtl/sum_reader.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sum_reader_pkg.sv
// sum_reader_pkg: shared constants for the pi engine's sum RAM and the
// read-out client, plus the reader FSM encoding and the FIFO entry layout.
//   N        limb width (base-1024 limbs)
//   L        number of limbs in the sum RAM
//   ADR_BITS sum RAM address width
//   RAMDELAY cycles from rd_addr registered to rd_data captured
//   DEPTH    reader output FIFO depth (power of 2, >= RAMDELAY+1)
package sum_reader_pkg;
  localparam int N        = 10;
  localparam int L        = 230;
  localparam int ADR_BITS = 10;
  localparam int RAMDELAY = 2;
  localparam int DEPTH    = 4;

  // One extra bit so the issue counter can go negative without aliasing
  // onto a real address.
  localparam int CNT_W = ADR_BITS + 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                last;
    logic [ADR_BITS-1:0] idx;
    logic [N-1:0]        q;
  } limb_t;
endpackage

// File: rtl/sum_reader_if.sv
// sum_reader_if: valid/ready limb stream from the sum reader to the
// display/VGA text path.
//   limb_q     limb value
//   limb_idx   RAM index of limb_q
//   limb_last  high with limb_idx == 0
//   limb_valid stream valid
//   limb_ready downstream accepts
// master = producer (sum_reader), slave = consumer.
interface sum_reader_if;
  import sum_reader_pkg::*;

  logic [N-1:0]        limb_q;
  logic [ADR_BITS-1:0] limb_idx;
  logic                limb_valid;
  logic                limb_ready;
  logic                limb_last;

  modport master (
    output limb_q, limb_idx, limb_valid, limb_last,
    input  limb_ready
  );

  modport slave (
    input  limb_q, limb_idx, limb_valid, limb_last,
    output limb_ready
  );
endinterface

// File: rtl/sum_reader_fifo.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_flush         empties the FIFO at the next edge (wins over push/pop)
//   i_push, i_data  write side (push while full is dropped)
//   i_pop           read side; o_data/o_valid show the head entry
//   o_count         current occupancy
module sync_fifo_fwft #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_data,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_data,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign w_pop  = i_pop  && (r_cnt != '0);
  assign w_push = i_push && (r_cnt != CW'(DEPTH));

  always_ff @(posedge i_clk)
    if (w_push && !i_flush) r_mem[r_wp] <= i_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_valid = (r_cnt != '0);
  assign o_count = r_cnt;
endmodule

// File: rtl/sum_reader.sv
// sum_reader: after the pi engine reaches END, walks the sum RAM from
// L-1 down to 0, absorbs the RAM read latency with a tag pipe and streams
// the limbs MSB-first through a small FWFT FIFO.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_start         one-cycle read-out request
//   i_calc_done     engine in END (RAM read port owned by this block)
//   o_rd_addr       sum RAM read address
//   i_rd_data       sum RAM read data
//   m_limb          limb stream (valid/ready)
//   o_busy          read-out in progress
//   o_done          one-cycle pulse after the last limb is accepted
//   o_abort         sticky: calc_done fell during a read-out
module sum_reader
  import sum_reader_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_calc_done,
  output logic [ADR_BITS-1:0] o_rd_addr,
  input  logic [N-1:0]        i_rd_data,
  sum_reader_if.master        m_limb,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_abort
);
  state_t                            r_state;
  logic signed [CNT_W-1:0]           r_cnt;
  logic [ADR_BITS-1:0]               r_rd_addr;
  logic [RAMDELAY-1:0]               r_vld_pipe;
  logic [RAMDELAY-1:0][ADR_BITS-1:0] r_idx_pipe;
  logic                              r_last_acc;
  logic                              r_busy, r_done, r_abort;

  logic             w_abort, w_credit, w_issue, w_push, w_pop, w_fifo_valid;
  logic [OCC_W-1:0] w_fifo_cnt;
  logic [7:0]       w_pipe_cnt;
  limb_t            w_wr, w_rd;

  // Losing the RAM port mid read-out kills everything in flight.
  assign w_abort = (r_state != ST_IDLE) && !i_calc_done;

  always_comb begin
    w_pipe_cnt = '0;
    for (int k = 0; k < RAMDELAY; k++)
      w_pipe_cnt = w_pipe_cnt + 8'(r_vld_pipe[k]);
  end

  // Every in-flight tag already owns a FIFO slot, so the FIFO can never
  // overflow and the RAM return path never needs to stall.
  assign w_credit = (w_pipe_cnt + 8'(w_fifo_cnt)) < 8'(DEPTH);
  assign w_issue  = (r_state == ST_ISSUE) && w_credit && !w_abort &&
                    !r_cnt[CNT_W-1];

  assign w_push  = r_vld_pipe[RAMDELAY-1] && !w_abort;
  assign w_wr.q    = i_rd_data;
  assign w_wr.idx  = r_idx_pipe[RAMDELAY-1];
  assign w_wr.last = (r_idx_pipe[RAMDELAY-1] == '0);
  assign w_pop   = w_fifo_valid && m_limb.limb_ready;

  sync_fifo_fwft #(
    .W     ($bits(limb_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_abort),
    .i_push  (w_push),
    .i_data  (w_wr),
    .i_pop   (w_pop),
    .o_data  (w_rd),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_cnt)
  );

  // Tag pipe: entry k is a read issued k+1 cycles ago; the last stage
  // lines up with the cycle its rd_data is on the bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      r_idx_pipe <= '0;
    end else if (w_abort) begin
      r_vld_pipe <= '0;
      r_idx_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_issue;
      r_idx_pipe[0] <= r_cnt[ADR_BITS-1:0];
      for (int k = 1; k < RAMDELAY; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_idx_pipe[k] <= r_idx_pipe[k-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= CNT_W'(L - 1);
      r_rd_addr  <= '0;
      r_last_acc <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop && w_rd.last) r_last_acc <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_start && i_calc_done) begin
            r_state    <= ST_ISSUE;
            r_cnt      <= CNT_W'(L - 1);
            r_abort    <= 1'b0;
            r_last_acc <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_ISSUE, ST_DRAIN: begin
          if (w_abort) begin
            r_state   <= ST_IDLE;
            r_abort   <= 1'b1;
            r_busy    <= 1'b0;
            r_rd_addr <= '0;
          end else if (r_state == ST_ISSUE) begin
            if (w_issue) begin
              r_rd_addr <= r_cnt[ADR_BITS-1:0];
              r_cnt     <= r_cnt - CNT_W'(1);
              if (r_cnt == '0) r_state <= ST_DRAIN;
            end
          end else if (r_last_acc && (r_vld_pipe == '0) && !w_fifo_valid) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_rd_addr <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_addr = r_rd_addr;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_abort   = r_abort;

  assign m_limb.limb_valid = w_fifo_valid;
  assign m_limb.limb_q     = w_fifo_valid ? w_rd.q   : '0;
  assign m_limb.limb_idx   = w_fifo_valid ? w_rd.idx : '0;
  assign m_limb.limb_last  = w_fifo_valid && w_rd.last;
endmodule
